// File: rtl/sprite_anim_renderer.sv
// Animated sprite renderer: 3-stage pixel pipeline feeding a sprite ROM and palette, plus a
// play/loop/one-shot frame sequencer. Define SPRITE_SCALE2X_EN to draw each texel as 2x2 pixels.
module sprite_anim_renderer #(
  parameter int unsigned SPR_W      = 64,
  parameter int unsigned SPR_H      = 64,
  parameter int unsigned NUM_FRAMES = 4,
  parameter int unsigned FRAME_HOLD = 6,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned TRANSP_IDX = 0,
  localparam int unsigned FW        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip_h,
  input  logic              play,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_on,
  output logic [FW-1:0]     cur_frame,
  output logic              anim_done
);

`ifdef SPRITE_SCALE2X_EN
  localparam int unsigned Shift = 1;
`else
  localparam int unsigned Shift = 0;
`endif

  localparam logic [10:0] BoxW = 11'(SPR_W << Shift);
  localparam logic [10:0] BoxH = 11'(SPR_H << Shift);
  localparam int unsigned HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [HW-1:0] HoldLast  = HW'(FRAME_HOLD - 1);
  localparam logic [FW-1:0] FrameLast = FW'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          done_q, done_d;

  logic [9:0]        rx, ry, tx_raw, ty, tx;
  logic              in_box;
  logic [ADDR_W-1:0] addr_d;
  logic              in_box1_q, blank1_q, in_box2_q, blank2_q;

  // 11-bit compares so a sprite hanging off the right/bottom edge clips instead of wrapping.
  always_comb begin
    rx     = DrawX - pos_x;
    ry     = DrawY - pos_y;
    in_box = ({1'b0, DrawX} >= {1'b0, pos_x}) && ({1'b0, DrawX} < ({1'b0, pos_x} + BoxW)) &&
             ({1'b0, DrawY} >= {1'b0, pos_y}) && ({1'b0, DrawY} < ({1'b0, pos_y} + BoxH));
    tx_raw = rx >> Shift;
    ty     = ry >> Shift;
    tx     = flip_h ? (10'(SPR_W - 1) - tx_raw) : tx_raw;
    addr_d = '0;
    if (in_box) begin
      addr_d = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H) + ADDR_W'(ty) * ADDR_W'(SPR_W) +
               ADDR_W'(tx);
    end
  end

  assign pal_index = rom_q;
  assign cur_frame = frame_q;
  assign anim_done = done_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address <= '0;
      in_box1_q   <= 1'b0;
      blank1_q    <= 1'b0;
      in_box2_q   <= 1'b0;
      blank2_q    <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      sprite_on   <= 1'b0;
    end else begin
      rom_address <= addr_d;
      in_box1_q   <= in_box;
      blank1_q    <= blank;
      in_box2_q   <= in_box1_q;
      blank2_q    <= blank1_q;
      if (blank2_q && in_box2_q && (rom_q != IDX_W'(TRANSP_IDX))) begin
        red       <= pal_red;
        green     <= pal_green;
        blue      <= pal_blue;
        sprite_on <= 1'b1;
      end else begin
        red       <= '0;
        green     <= '0;
        blue      <= '0;
        sprite_on <= 1'b0;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle: begin
        frame_d = '0;
        done_d  = 1'b0;
        if (frame_start && play) begin
          state_d = StPlay;
          hold_d  = '0;
        end
      end
      StPlay: begin
        if (!play) begin
          state_d = StIdle;
          hold_d  = '0;
          frame_d = '0;
          done_d  = 1'b0;
        end else if (frame_start) begin
          if (hold_q == HoldLast) begin
            hold_d = '0;
            if (frame_q == FrameLast) begin
              if (loop) begin
                frame_d = '0;
              end else begin
                state_d = StDone;
                done_d  = 1'b1;
              end
            end else begin
              frame_d = frame_q + FW'(1);
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      StDone: begin
        // Holding on the last frame; only dropping play leaves this state.
        if (!play) begin
          state_d = StIdle;
          hold_d  = '0;
          frame_d = '0;
          done_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Bench for sprite_anim_renderer: hand vectors, animation sequences and randomized pixels
// checked against a spec-level model of the pixel mapping and animation timing.
module tb_sprite_anim_renderer;

  localparam int SPR_W = 64;
  localparam int SPR_H = 64;
  localparam int NF    = 4;
  localparam int FH    = 6;
  localparam int TRANSP = 0;
`ifdef SPRITE_SCALE2X_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic        vga_clk = 1'b0;
  logic        reset, blank, frame_start, flip_h, play, loop;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic [13:0] rom_address;
  logic [3:0]  rom_q, pal_index, pal_red, pal_green, pal_blue, red, green, blue;
  logic        sprite_on, anim_done;
  logic [1:0]  cur_frame;

  logic [3:0] rom [0:16383];

  sprite_anim_renderer #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NF), .FRAME_HOLD(FH),
    .ADDR_W(14), .IDX_W(4), .TRANSP_IDX(TRANSP)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
    .play(play), .loop(loop), .rom_address(rom_address), .rom_q(rom_q),
    .pal_index(pal_index), .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .sprite_on(sprite_on),
    .cur_frame(cur_frame), .anim_done(anim_done)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= rom[rom_address];
  assign pal_red   = pal_index;
  assign pal_green = ~pal_index;
  assign pal_blue  = pal_index ^ 4'h5;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {int addr; bit on; int rgb;} pix_t;
  pix_t p1, p2, p3, zero_pix;

  // Animation model: frame_starts counted since playback began.
  bit m_active = 0;
  int m_n = 0;

  function automatic int pal_rgb(int idx);
    logic [3:0] i;
    i = 4'(idx);
    return int'({i, ~i, i ^ 4'h5});
  endfunction

  function automatic bit model_done();
    return m_active && !loop && (m_n / FH >= NF);
  endfunction

  function automatic int model_frame();
    if (!m_active) return 0;
    if (loop) return (m_n / FH) % NF;
    return (m_n / FH >= NF) ? NF - 1 : m_n / FH;
  endfunction

  function automatic pix_t pix_model(int x, int y, int px, int py, bit fl, bit bl, int frame);
    pix_t r;
    int tx, ty, idx;
    r = '{0, 0, 0};
    if (x >= px && x < px + SPR_W * S && y >= py && y < py + SPR_H * S) begin
      tx = (x - px) / S;
      ty = (y - py) / S;
      if (fl) tx = SPR_W - 1 - tx;
      r.addr = frame * SPR_W * SPR_H + ty * SPR_W + tx;
      idx    = int'(rom[r.addr]);
      r.on   = bl && (idx != TRANSP);
      r.rgb  = r.on ? pal_rgb(idx) : 0;
    end
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    pix_t e;
    bit r, fs, pl;
    e  = pix_model(int'(DrawX), int'(DrawY), int'(pos_x), int'(pos_y), flip_h, blank,
                   model_frame());
    r  = reset;
    fs = frame_start;
    pl = play;
    @(posedge vga_clk);
    if (r) begin
      m_active = 0;
      m_n = 0;
      p1 = zero_pix; p2 = zero_pix; p3 = zero_pix;
    end else begin
      if (!m_active) begin
        if (fs && pl) begin m_active = 1; m_n = 0; end
      end else if (!pl) begin
        m_active = 0;
        m_n = 0;
      end else if (fs && !model_done()) begin
        m_n++;
      end
      p3 = p2; p2 = p1; p1 = e;
    end
    #1;
    chk("model rom_address", int'(rom_address), p1.addr);
    chk("model sprite_on", int'(sprite_on), int'(p3.on));
    chk("model rgb", int'({red, green, blue}), p3.rgb);
    chk("model cur_frame", int'(cur_frame), model_frame());
    chk("model anim_done", int'(anim_done), int'(model_done()));
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  typedef struct {int x, y, px, py; bit fl, bl; int addr; bit on; int idx;} vec_t;
  vec_t vt [11];

  initial begin
    bit prev_play;
    int v;
    zero_pix = '{0, 0, 0};
    p1 = zero_pix; p2 = zero_pix; p3 = zero_pix;
    for (int i = 0; i < 16384; i++) rom[i] = 4'($urandom_range(0, 15));
    rom[0] = 4'd3; rom[63] = 4'd7; rom[330] = 4'd0; rom[39] = 4'd9;
    rom[10] = 4'd12; rom[4032] = 4'd5; rom[4096] = 4'd3;

    vt[0]  = '{100, 50, 100, 50, 0, 1, 0, 1, 3};
    vt[1]  = '{100, 50, 100, 50, 1, 1, 63, 1, 7};
    vt[2]  = '{99, 50, 100, 50, 1, 1, 0, 0, 0};
    vt[3]  = '{110, 55, 100, 50, 0, 1, 330, 0, 0};
    vt[4]  = '{100, 50, 100, 50, 0, 0, 0, 0, 0};
    vt[5]  = '{639, 10, 600, 10, 0, 1, 39, 1, 9};
    vt[6]  = '{640, 10, 600, 10, 0, 0, 40, 0, 0};
    vt[7]  = '{1010, 10, 1000, 10, 0, 1, 10, 1, 12};
    vt[8]  = '{100, 113, 100, 50, 0, 1, 4032, 1, 5};
    vt[9]  = '{100, 114, 100, 50, 0, 1, 0, 0, 0};
    vt[10] = '{163, 50, 100, 50, 1, 1, 0, 1, 3};

    reset = 1'b1; blank = 1'b0; frame_start = 1'b0; flip_h = 1'b0; play = 1'b0; loop = 1'b0;
    DrawX = '0; DrawY = '0; pos_x = '0; pos_y = '0;
    repeat (3) step();
    chk("reset sprite_on", int'(sprite_on), 0);
    chk("reset rgb", int'({red, green, blue}), 0);
    chk("reset rom_address", int'(rom_address), 0);
    chk("reset anim_done", int'(anim_done), 0);
    reset = 1'b0;
    step();

`ifndef SPRITE_SCALE2X_EN
    for (int i = 0; i < 11; i++) begin
      DrawX = 10'(vt[i].x); DrawY = 10'(vt[i].y);
      pos_x = 10'(vt[i].px); pos_y = 10'(vt[i].py);
      flip_h = vt[i].fl; blank = vt[i].bl;
      repeat (4) step();
      chk($sformatf("vec%0d rom_address", i), int'(rom_address), vt[i].addr);
      chk($sformatf("vec%0d sprite_on", i), int'(sprite_on), int'(vt[i].on));
      chk($sformatf("vec%0d rgb", i), int'({red, green, blue}), vt[i].on ? pal_rgb(vt[i].idx) : 0);
    end

    // Looping playback: frame advances every FH frame_starts after entering play.
    DrawX = 10'd100; DrawY = 10'd50; pos_x = 10'd100; pos_y = 10'd50;
    flip_h = 1'b0; blank = 1'b1; play = 1'b1; loop = 1'b1;
    fs_pulse();
    chk("loop start frame", int'(cur_frame), 0);
    for (int k = 1; k <= 24; k++) begin
      fs_pulse();
      chk($sformatf("loop frame k=%0d", k), int'(cur_frame), (k / 6) % 4);
      if (k == 12) chk("frame2 rom_address", int'(rom_address), 8192);
    end
    repeat (6) fs_pulse();
    chk("loop frame 1 again", int'(cur_frame), 1);
    play = 1'b0;
    step();
    chk("stop frame", int'(cur_frame), 0);

    // One-shot playback.
    loop = 1'b0; play = 1'b1;
    fs_pulse();
    repeat (23) fs_pulse();
    chk("oneshot pre-done frame", int'(cur_frame), 3);
    chk("oneshot pre-done flag", int'(anim_done), 0);
    fs_pulse();
    chk("oneshot done frame", int'(cur_frame), 3);
    chk("oneshot done flag", int'(anim_done), 1);
    repeat (3) fs_pulse();
    chk("oneshot hold frame", int'(cur_frame), 3);
    chk("oneshot hold flag", int'(anim_done), 1);
    play = 1'b0;
    step();
    chk("oneshot drop frame", int'(cur_frame), 0);
    chk("oneshot drop flag", int'(anim_done), 0);

    // Reset in the middle of an animation with an opaque pixel on screen.
    play = 1'b1; loop = 1'b1;
    fs_pulse();
    repeat (6) fs_pulse();
    repeat (3) step();
    chk("pre-reset frame", int'(cur_frame), 1);
    chk("pre-reset sprite_on", int'(sprite_on), 1);
    reset = 1'b1;
    step();
    chk("mid reset sprite_on", int'(sprite_on), 0);
    chk("mid reset rgb", int'({red, green, blue}), 0);
    chk("mid reset rom_address", int'(rom_address), 0);
    chk("mid reset cur_frame", int'(cur_frame), 0);
    reset = 1'b0;
    play = 1'b0;
    step();
`endif

    // Randomized traffic around the sprite box.
    prev_play = play;
    for (int i = 0; i < 3000; i++) begin
      pos_x = 10'($urandom_range(0, 1023));
      pos_y = 10'($urandom_range(0, 1023));
      v = int'(pos_x) + $urandom_range(0, 64 * S + 16) - 8;
      DrawX = 10'(v);
      v = int'(pos_y) + $urandom_range(0, 64 * S + 16) - 8;
      DrawY = 10'(v);
      flip_h = 1'($urandom_range(0, 1));
      blank = ($urandom_range(0, 7) != 0);
      frame_start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 149) == 0) play = ~play;
      if (!play && !prev_play) loop = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 799) == 0);
      prev_play = play;
      step();
    end
    reset = 1'b0;
    frame_start = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
